// File: rtl/mem_seq.sv
// mem_seq: sequences 1/2/4-byte read, write, push and pop requests as little-endian byte beats on an 8-bit bus.
module mem_seq #(
  parameter int AW   = 20,
  parameter int MAXB = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [AW-1:0]     base,
  input  logic [8*MAXB-1:0] wdata,
  input  logic              mem_ready,
  input  logic [7:0]        data,
  output logic [AW-1:0]     address,
  output logic [7:0]        out,
  output logic              wren,
  output logic              busy,
  output logic              done,
  output logic [8*MAXB-1:0] rdata,
  output logic [AW-1:0]     new_sp
);
  typedef enum logic [2:0] {IDLE, WR, RA, RC, FIN} state_t;
  state_t state, state_nx;
  logic [2:0] k, n_r, n_raw, n_in;
  logic [1:0] op_r;
  logic sext_r, last, sgn;
  logic [AW-1:0] base_r, a_r, a_in, sp_nx;
  logic [8*MAXB-1:0] wdata_r, rd_nx;
  always_comb begin
    n_raw = size == 2'd0 ? 3'd1 : size == 2'd1 ? 3'd2 : size == 2'd2 ? 3'd4 : 3'(MAXB);
    n_in  = n_raw > 3'(MAXB) ? 3'(MAXB) : n_raw;
    a_in  = op == 2'b10 ? base - AW'(n_in) : base;
    last  = k == n_r - 3'd1;
    sp_nx = op_r == 2'b10 ? a_r : op_r == 2'b11 ? base_r + AW'(n_r) : base_r;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    wren = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    out = 8'h00;
    case (state)
      IDLE: if (start) state_nx = (op[1] ^ op[0]) ? WR : RA;
      WR: begin
        wren = 1'b1;
        busy = 1'b1;
        out = 8'(wdata_r >> {k, 3'b000});
        if (mem_ready && last) state_nx = FIN;
      end
      RA: begin
        busy = 1'b1;
        if (mem_ready) state_nx = RC;
      end
      RC: begin
        busy = 1'b1;
        if (mem_ready) state_nx = last ? FIN : RA;
      end
      FIN: begin
        done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  // Upper bytes are refilled on every capture; only the final capture's fill survives.
  always_comb begin
    rd_nx = rdata;
    for (int j = 0; j < MAXB; j++) if (j == int'(k)) rd_nx[8*j +: 8] = data;
    sgn = sext_r & 1'(rd_nx >> {n_r - 3'd1, 3'b111});
    for (int j = 0; j < MAXB; j++) if (j >= int'(n_r)) rd_nx[8*j +: 8] = {8{sgn}};
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      k <= '0;
      n_r <= 3'd1;
      op_r <= '0;
      sext_r <= 1'b0;
      base_r <= '0;
      a_r <= '0;
      wdata_r <= '0;
      address <= '0;
      rdata <= '0;
      new_sp <= '0;
    end else begin
      if (state == IDLE && start) begin
        k <= '0;
        address <= a_in;
        a_r <= a_in;
        n_r <= n_in;
        op_r <= op;
        sext_r <= sext;
        base_r <= base;
        wdata_r <= wdata;
      end
      if (mem_ready && !last && (state == WR || state == RC)) begin
        k <= k + 3'd1;
        address <= address + AW'(1);
      end
      if (state == RC && mem_ready) rdata <= rd_nx;
      if (state_nx == FIN && state != FIN) new_sp <= sp_nx;
    end
endmodule

// File: tb/tb_mem_seq.sv
// tb_mem_seq: scoreboard bench for mem_seq with a byte-wide bus memory model and wait-state injection.
module tb_mem_seq;
  logic clock = 1'b0, reset_n = 1'b0, start = 1'b0, sext = 1'b0, mem_ready = 1'b1;
  logic [1:0] op = '0, size = '0;
  logic [19:0] base = '0;
  logic [31:0] wdata = '0;
  logic [7:0] data, out;
  logic [19:0] address, new_sp;
  logic wren, busy, done;
  logic [31:0] rdata;
  logic [7:0] bm [0:(1<<20)-1];
  logic [7:0] mm [0:(1<<20)-1];
  typedef struct {logic [19:0] a; logic [7:0] b;} beat_t;
  typedef struct {logic [31:0] rd; logic [19:0] sp; int lat;} exp_t;
  beat_t wq[$];
  exp_t dq[$];
  int n_chk = 0, n_pass = 0, cyc = 0, t0 = 0, waits = 0;
  logic [31:0] last_rd = '0;

  mem_seq #(.AW(20), .MAXB(4)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op(op), .size(size), .sext(sext),
    .base(base), .wdata(wdata), .mem_ready(mem_ready), .data(data), .address(address),
    .out(out), .wren(wren), .busy(busy), .done(done), .rdata(rdata), .new_sp(new_sp)
  );

  assign data = bm[address];
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic poke(input logic [19:0] a, input logic [7:0] b);
    bm[a] = b;
    mm[a] = b;
  endtask

  task automatic tick(input logic r);
    beat_t bt;
    exp_t e;
    @(negedge clock);
    cyc++;
    if (wren && mem_ready) begin
      if (wq.size() == 0) chk("wr_extra", 64'd1, 64'd0);
      else begin
        bt = wq.pop_front();
        chk("wr_addr", 64'(address), 64'(bt.a));
        chk("wr_byte", 64'(out), 64'(bt.b));
      end
      bm[address] = out;
    end
    if (done) begin
      if (dq.size() == 0) chk("done_extra", 64'd1, 64'd0);
      else begin
        e = dq.pop_front();
        chk("rdata", 64'(rdata), 64'(e.rd));
        chk("new_sp", 64'(new_sp), 64'(e.sp));
        chk("latency", 64'(cyc - t0), 64'(e.lat + waits));
        chk("busy_at_done", 64'(busy), 64'd0);
      end
    end
    mem_ready = r;
    if (dq.size() > 0 && !r) waits++;
  endtask

  task automatic issue(input logic [1:0] o, input logic [1:0] sz, input logic sx,
                       input logic [19:0] b, input logic [31:0] w, input logic r);
    int n;
    logic [19:0] a;
    logic [31:0] v;
    beat_t bt;
    exp_t e;
    n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    a = o == 2'b10 ? b - 20'(n) : b;
    v = '0;
    if (o == 2'b01 || o == 2'b10) begin
      for (int j = 0; j < n; j++) begin
        bt.a = a + 20'(j);
        bt.b = w[8*j +: 8];
        wq.push_back(bt);
        mm[bt.a] = bt.b;
      end
      e.lat = n + 1;
    end else begin
      for (int j = 0; j < n; j++) v[8*j +: 8] = mm[a + 20'(j)];
      for (int j = n; j < 4; j++) v[8*j +: 8] = {8{sx & v[8*n-1]}};
      last_rd = v;
      e.lat = 2 * n + 1;
    end
    e.rd = last_rd;
    e.sp = o == 2'b10 ? a : o == 2'b11 ? b + 20'(n) : b;
    dq.push_back(e);
    op = o; size = sz; sext = sx; base = b; wdata = w; start = 1'b1;
    t0 = cyc;
    waits = 0;
    tick(r);
    start = 1'b0;
    op = 2'($urandom); size = 2'($urandom); sext = 1'($urandom);
    base = 20'($urandom); wdata = $urandom;
  endtask

  task automatic wait_done(input bit rnd);
    for (int i = 0; i < 200 && dq.size() > 0; i++)
      tick(rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
    chk("timeout", 64'(dq.size()), 64'd0);
    chk("wr_left", 64'(wq.size()), 64'd0);
    dq.delete();
    wq.delete();
    tick(1'b1);
  endtask

  initial begin
    #1;
    chk("rst_address", 64'(address), 64'd0);
    chk("rst_out", 64'(out), 64'd0);
    chk("rst_wren", 64'(wren), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_new_sp", 64'(new_sp), 64'd0);
    poke(20'h00100, 8'h80);
    poke(20'hFFFFE, 8'h11); poke(20'hFFFFF, 8'h22); poke(20'h00000, 8'h33); poke(20'h00001, 8'h44);
    poke(20'h00400, 8'h01); poke(20'h00401, 8'hF0);
    poke(20'h00600, 8'hA1); poke(20'h00601, 8'hB2); poke(20'h00602, 8'hC3); poke(20'h00603, 8'hD4);
    for (int i = 0; i < 32; i++) poke(20'hFFFF0 + 20'(i), 8'($urandom));
    tick(1'b1);
    reset_n = 1'b1;
    tick(1'b1);
    issue(2'b01, 2'd1, 1'b0, 20'h12345, 32'h0000BEEF, 1'b1);
    wait_done(0);
    issue(2'b00, 2'd0, 1'b1, 20'h00100, 32'h0, 1'b1);
    wait_done(0);
    issue(2'b00, 2'd0, 1'b0, 20'h00100, 32'h0, 1'b1);
    wait_done(0);
    issue(2'b10, 2'd1, 1'b0, 20'h0FFFE, 32'h00001234, 1'b1);
    wait_done(0);
    issue(2'b11, 2'd1, 1'b0, 20'h0FFFC, 32'h0, 1'b1);
    wait_done(0);
    issue(2'b00, 2'd2, 1'b0, 20'hFFFFE, 32'h0, 1'b1);
    wait_done(0);
    issue(2'b00, 2'd1, 1'b1, 20'h00400, 32'h0, 1'b1);
    wait_done(0);
    // Three wait states on byte 0 plus an ignored start pulse while busy.
    issue(2'b01, 2'd1, 1'b0, 20'h00200, 32'h0000A55A, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("wait_address", 64'(address), 64'h00200);
      chk("wait_out", 64'(out), 64'h5A);
      chk("wait_wren", 64'(wren), 64'd1);
      if (i == 1) begin start = 1'b1; op = 2'b00; end
      if (i == 2) start = 1'b0;
      if (i < 2) tick(1'b0);
    end
    wait_done(0);
    for (int i = 0; i < 4; i++) tick(1'b1);
    chk("idle_busy", 64'(busy), 64'd0);
    // Asynchronous reset while byte 1 of a 4-byte write is on the bus.
    issue(2'b01, 2'd2, 1'b0, 20'h00500, 32'h11223344, 1'b1);
    tick(1'b1);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_wren", 64'(wren), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_address", 64'(address), 64'd0);
    wq.delete();
    dq.delete();
    last_rd = '0;
    tick(1'b1);
    reset_n = 1'b1;
    tick(1'b1);
    issue(2'b00, 2'd3, 1'b0, 20'h00600, 32'h0, 1'b1);
    wait_done(0);
    for (int i = 0; i < 12; i++) begin
      issue(2'($urandom), 2'($urandom), 1'($urandom), 20'hFFFF8 + 20'($urandom_range(0, 15)),
            $urandom, 1'($urandom_range(0, 3) != 0));
      wait_done(1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_seq.md
Name: mem_seq

Overview:
- Parametrised multi-byte memory access sequencer between the execution unit and the 8-bit external bus.
- Turns a single read, write, push or pop request of 1, 2 or 4 bytes into a little-endian byte sequence on address/out/wren/data.
- Supports bus wait states via mem_ready, sign/zero extension of reads, and stack-pointer update for push/pop.
- Replaces hand-coded per-instruction byte sequencing and register/memory writeback.

Parameters:
- AW, 20, bus address width.
- MAXB, 4, maximum operand bytes; legal values 1, 2, 4.

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request strobe, sampled only while busy=0.
- op  in  2  00 read, 01 write, 10 push, 11 pop.
- size  in  2  0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes, 3 = MAXB.
- sext  in  1  reads/pops: 1 = sign-extend, 0 = zero-extend into rdata.
- base  in  AW  byte address (read/write) or current stack pointer (push/pop).
- wdata  in  8*MAXB  write/push operand, byte 0 = LSB.
- mem_ready  in  1  bus ready; 0 = wait state.
- data  in  8  bus read data.
- address  out  AW  bus address.
- out  out  8  bus write data.
- wren  out  1  bus write enable.
- busy  out  1  request in progress.
- done  out  1  one-cycle completion pulse.
- rdata  out  8*MAXB  read/pop result, extended to full width.
- new_sp  out  AW  updated pointer; valid when done=1.

Behaviour:
- Reset (asynchronous, immediate, also mid-transfer): address=0, out=0, wren=0, busy=0, done=0, rdata=0, new_sp=0, state IDLE, byte index k=0.
- n = bytes(size), clamped to MAXB.
- Start address A (all address arithmetic modulo 2^AW):
  - push: A = base − n
  - read, write, pop: A = base
- States: IDLE, WR, RA (read address), RC (read capture), FIN.
- IDLE, start=1 at a clock edge:
  - busy←1, k←0, address←A, operand latched.
  - Next state WR (write/push) or RA (read/pop).
  - start=0: stay IDLE.
- WR:
  - wren=1, out=byte k of the latched operand, address=A+k.
  - Edge with mem_ready=1 and k<n−1: k←k+1, address←A+k+1.
  - Edge with mem_ready=1 and k=n−1: wren←0, go to FIN.
  - mem_ready=0: address, out and wren hold.
- RA: wren=0, address=A+k. Edge with mem_ready=1 → RC.
- RC:
  - Edge with mem_ready=1: rdata byte k←data.
  - k<n−1: k←k+1, address←A+k+1, go to RA.
  - k=n−1: go to FIN.
  - mem_ready=0: hold, no capture.
- FIN (one cycle):
  - done=1, busy=0.
  - rdata bytes n..MAXB−1 are filled with the sign bit of byte n−1 if sext=1, otherwise 0.
  - new_sp = A for push, base+n for pop, base for read/write.
  - Next state IDLE.
  - start is not accepted in FIN; it is accepted from the following cycle.
- Latency with no wait states, counted from the start edge to done:
  - write/push: n+1 cycles.
  - read/pop: 2n+1 cycles.
  - Each mem_ready=0 cycle adds one cycle.
- start while busy=1: ignored, no queuing.
- Operand inputs (op, size, sext, base, wdata) are latched at the start edge and may change afterwards.
- rdata holds its value until the next read/pop completes; write/push leaves rdata unchanged.
- Address wraps past 2^AW−1 to 0 mid-sequence, with no error.

Test Plan:
- Write, size=1, base=20'h12345, wdata=0xBEEF, mem_ready=1 → cycle 1: address 12345, out EF, wren=1. Cycle 2: address 12346, out BE. Cycle 3: done=1, wren=0, new_sp=12345.
- Read, size=0, sext=1, memory[0x00100]=0x80, MAXB=4 → done at cycle 3, rdata=0xFFFFFF80. Repeat with sext=0 → rdata=0x00000080.
- Push, size=1, base=0x0FFFE, wdata=0x1234 → writes 34@0FFFC, then 12@0FFFD. new_sp=0FFFC. Follow with pop, base=0FFFC, size=1 → rdata=0x00001234, new_sp=0FFFE.
- Read, size=2, base=20'hFFFFE, memory bytes 11,22,33,44 at FFFFE,FFFFF,00000,00001 → address wraps to 0. rdata=0x44332211, done at cycle 9.
- Write, size=1, mem_ready held 0 for 3 cycles on byte 0 → address, out and wren=1 stay stable throughout. done arrives 3 cycles later than the no-wait case. A start pulse during busy is ignored.
- reset_n low during byte 1 of a 4-byte write → wren, busy and done drop to 0 immediately, before the next clock edge. After release, a fresh read completes normally.
